// File: rtl/bsg_id_pool.sv
// Single-port ID pool without reserve, built on bsg_id_pool_mp.
module bsg_id_pool #(
  parameter int  els_p          = 1,
  localparam int id_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic [id_width_lp-1:0]    alloc_id_o,
  output logic                      alloc_v_o,
  input  logic                      alloc_yumi_i,
  input  logic                      dealloc_v_i,
  input  logic [id_width_lp-1:0]    dealloc_id_i,
  output logic [count_width_lp-1:0] free_count_o,
  output logic                      all_free_o,
  output logic                      error_o
);

  bsg_id_pool_mp #(
    .els_p           (els_p),
    .dealloc_ports_p (1),
    .reserve_els_p   (0)
  ) pool (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .alloc_id_o       (alloc_id_o),
    .alloc_v_o        (alloc_v_o),
    .alloc_yumi_i     (alloc_yumi_i),
    .alloc_priority_i (1'b0),
    .dealloc_v_i      (dealloc_v_i),
    .dealloc_id_i     (dealloc_id_i),
    .free_count_o     (free_count_o),
    .all_free_o       (all_free_o),
    .error_o          (error_o)
  );

endmodule

// File: rtl/bsg_id_pool_mp_dealloc_check.sv
// Per-port deallocation legality for bsg_id_pool_mp. Produces the combined clear mask,
// the number of IDs it returns, and a flag for any valid port that was rejected.
module bsg_id_pool_mp_dealloc_check #(
  parameter int els_p           = 1,
  parameter int dealloc_ports_p = 1,
  parameter int id_width_lp     = 1,
  parameter int count_width_lp  = 1
) (
  input  logic [els_p-1:0]                       used_i,
  input  logic [dealloc_ports_p-1:0]             dealloc_v_i,
  input  logic [dealloc_ports_p*id_width_lp-1:0] dealloc_id_i,
  output logic [els_p-1:0]                       clear_mask_o,
  output logic [count_width_lp-1:0]              clear_count_o,
  output logic                                   illegal_o
);

  logic [id_width_lp-1:0] port_id    [dealloc_ports_p];
  logic [els_p-1:0]       port_mask  [dealloc_ports_p];
  logic [dealloc_ports_p-1:0] legal;
  logic [dealloc_ports_p-1:0] dup;

  // A later port repeating an ID already presented by a lower port loses.
  always_comb begin
    dup = '0;
    for (int p = 1; p < dealloc_ports_p; p++) begin
      for (int q = 0; q < p; q++) begin
        if (dealloc_v_i[q] && (port_id[q] == port_id[p])) dup[p] = 1'b1;
      end
    end
  end

  genvar gp, gi;
  generate
    for (gp = 0; gp < dealloc_ports_p; gp++) begin : g_port
      logic [els_p-1:0] onehot;
      assign port_id[gp] = dealloc_id_i[gp*id_width_lp +: id_width_lp];
      // Out-of-range IDs decode to all zeros, so they never hit a used bit.
      for (gi = 0; gi < els_p; gi++) begin : g_dec
        assign onehot[gi] = (port_id[gp] == id_width_lp'(gi));
      end
      assign legal[gp]     = dealloc_v_i[gp] & (|(onehot & used_i)) & ~dup[gp];
      assign port_mask[gp] = legal[gp] ? onehot : '0;
    end
  endgenerate

  always_comb begin
    clear_mask_o = '0;
    for (int p = 0; p < dealloc_ports_p; p++) clear_mask_o = clear_mask_o | port_mask[p];
  end

  always_comb begin
    clear_count_o = '0;
    for (int i = 0; i < els_p; i++) clear_count_o = clear_count_o + count_width_lp'(clear_mask_o[i]);
  end

  assign illegal_o = |(dealloc_v_i & ~legal);

endmodule

// File: rtl/bsg_id_pool_mp.sv
// Multi-port ID pool: one allocation port handing out the lowest free ID, several
// deallocation ports, a reserve threshold with priority override, and a sticky error flag.
module bsg_id_pool_mp #(
  parameter int  els_p           = 1,
  parameter int  dealloc_ports_p = 2,
  parameter int  reserve_els_p   = 0,
  localparam int id_width_lp     = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int count_width_lp  = $clog2(els_p + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  output logic [id_width_lp-1:0]                 alloc_id_o,
  output logic                                   alloc_v_o,
  input  logic                                   alloc_yumi_i,
  input  logic                                   alloc_priority_i,
  input  logic [dealloc_ports_p-1:0]             dealloc_v_i,
  input  logic [dealloc_ports_p*id_width_lp-1:0] dealloc_id_i,
  output logic [count_width_lp-1:0]              free_count_o,
  output logic                                   all_free_o,
  output logic                                   error_o
);

  logic [els_p-1:0]          used_q, used_d, alloc_mask, clear_mask;
  logic [count_width_lp-1:0] free_cnt_q, free_cnt_d, clear_count;
  logic                      error_q, error_d, illegal, yumi_eff;

  always_comb begin
    alloc_id_o = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (!used_q[i]) alloc_id_o = id_width_lp'(i);
    end
  end

  assign alloc_v_o = (free_cnt_q > count_width_lp'(reserve_els_p))
                   | (alloc_priority_i & (free_cnt_q != '0));
  // A yumi without a valid grant is dropped rather than corrupting the pool.
  assign yumi_eff  = alloc_yumi_i & alloc_v_o;

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_alloc_dec
      assign alloc_mask[gi] = yumi_eff & (alloc_id_o == id_width_lp'(gi));
    end
  endgenerate

  bsg_id_pool_mp_dealloc_check #(
    .els_p           (els_p),
    .dealloc_ports_p (dealloc_ports_p),
    .id_width_lp     (id_width_lp),
    .count_width_lp  (count_width_lp)
  ) dealloc_check (
    .used_i        (used_q),
    .dealloc_v_i   (dealloc_v_i),
    .dealloc_id_i  (dealloc_id_i),
    .clear_mask_o  (clear_mask),
    .clear_count_o (clear_count),
    .illegal_o     (illegal)
  );

  // Set and clear masks are disjoint: legality only accepts IDs already used.
  assign used_d     = (used_q | alloc_mask) & ~clear_mask;
  assign free_cnt_d = free_cnt_q - count_width_lp'(yumi_eff) + clear_count;
  assign error_d    = error_q | illegal;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      used_q     <= '0;
      free_cnt_q <= count_width_lp'(els_p);
      error_q    <= 1'b0;
    end else begin
      used_q     <= used_d;
      free_cnt_q <= free_cnt_d;
      error_q    <= error_d;
    end
  end

  assign free_count_o = free_cnt_q;
  assign all_free_o   = (free_cnt_q == count_width_lp'(els_p));
  assign error_o      = error_q;

  alloc_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    alloc_yumi_i |-> alloc_v_o);

endmodule

// File: tb/tb_bsg_id_pool_mp.sv
// Directed vector bench for bsg_id_pool_mp: a 4-entry pool with reserve 1 and a
// 5-entry pool used for out-of-range deallocation.
module tb_bsg_id_pool_mp;

  logic clk, rst;

  logic       a_yumi, a_prio;
  logic [1:0] a_dv;
  logic [1:0] a_id0, a_id1;
  logic [1:0] a_alloc_id;
  logic       a_alloc_v, a_all_free, a_err;
  logic [2:0] a_cnt;

  logic       b_yumi, b_prio;
  logic [1:0] b_dv;
  logic [5:0] b_did;
  logic [2:0] b_alloc_id;
  logic       b_alloc_v, b_all_free, b_err;
  logic [2:0] b_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  bsg_id_pool_mp #(.els_p(4), .dealloc_ports_p(2), .reserve_els_p(1)) dut_a (
    .clk_i            (clk),
    .reset_i          (rst),
    .alloc_id_o       (a_alloc_id),
    .alloc_v_o        (a_alloc_v),
    .alloc_yumi_i     (a_yumi),
    .alloc_priority_i (a_prio),
    .dealloc_v_i      (a_dv),
    .dealloc_id_i     ({a_id1, a_id0}),
    .free_count_o     (a_cnt),
    .all_free_o       (a_all_free),
    .error_o          (a_err)
  );

  bsg_id_pool_mp #(.els_p(5), .dealloc_ports_p(2), .reserve_els_p(0)) dut_b (
    .clk_i            (clk),
    .reset_i          (rst),
    .alloc_id_o       (b_alloc_id),
    .alloc_v_o        (b_alloc_v),
    .alloc_yumi_i     (b_yumi),
    .alloc_priority_i (b_prio),
    .dealloc_v_i      (b_dv),
    .dealloc_id_i     (b_did),
    .free_count_o     (b_cnt),
    .all_free_o       (b_all_free),
    .error_o          (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       yumi, prio;
    logic [1:0] dv, id0, id1;
    logic [1:0] e_id;
    logic       e_v;
    logic [2:0] e_cnt;
    logic       e_af, e_err;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic y, input logic p, input logic [1:0] dv,
                              input logic [1:0] i0, input logic [1:0] i1,
                              input logic [1:0] eid, input logic ev, input logic [2:0] ec,
                              input logic eaf, input logic ee);
    vec_t v;
    v.yumi = y; v.prio = p; v.dv = dv; v.id0 = i0; v.id1 = i1;
    v.e_id = eid; v.e_v = ev; v.e_cnt = ec; v.e_af = eaf; v.e_err = ee;
    return v;
  endfunction

  task automatic chk_a(input string name, input logic [1:0] eid, input logic ev,
                       input logic [2:0] ec, input logic eaf, input logic ee);
    n_vec++;
    if (a_alloc_id !== eid || a_alloc_v !== ev || a_cnt !== ec || a_all_free !== eaf || a_err !== ee) begin
      n_miss++;
      $display("FAIL %s: got id=%0d v=%0b cnt=%0d all_free=%0b err=%0b, expected id=%0d v=%0b cnt=%0d all_free=%0b err=%0b",
               name, a_alloc_id, a_alloc_v, a_cnt, a_all_free, a_err, eid, ev, ec, eaf, ee);
    end else begin
      $display("ok   %s: id=%0d v=%0b cnt=%0d all_free=%0b err=%0b",
               name, a_alloc_id, a_alloc_v, a_cnt, a_all_free, a_err);
    end
  endtask

  task automatic chk_b(input string name, input logic [2:0] eid, input logic ev,
                       input logic [2:0] ec, input logic eaf, input logic ee);
    n_vec++;
    if (b_alloc_id !== eid || b_alloc_v !== ev || b_cnt !== ec || b_all_free !== eaf || b_err !== ee) begin
      n_miss++;
      $display("FAIL %s: got id=%0d v=%0b cnt=%0d all_free=%0b err=%0b, expected id=%0d v=%0b cnt=%0d all_free=%0b err=%0b",
               name, b_alloc_id, b_alloc_v, b_cnt, b_all_free, b_err, eid, ev, ec, eaf, ee);
    end else begin
      $display("ok   %s: id=%0d v=%0b cnt=%0d all_free=%0b err=%0b",
               name, b_alloc_id, b_alloc_v, b_cnt, b_all_free, b_err);
    end
  endtask

  task automatic idle_a();
    a_yumi = 1'b0; a_prio = 1'b0; a_dv = 2'b00; a_id0 = 2'd0; a_id1 = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_a();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // yumi prio dv id0 id1 | id v cnt all_free err  (outputs seen before the edge)
    vecs[0]  = mk(0, 0, 2'b00, 0, 0,  0, 1, 4, 1, 0);
    vecs[1]  = mk(1, 0, 2'b00, 0, 0,  0, 1, 4, 1, 0);
    vecs[2]  = mk(1, 0, 2'b00, 0, 0,  1, 1, 3, 0, 0);
    vecs[3]  = mk(1, 0, 2'b00, 0, 0,  2, 1, 2, 0, 0);
    vecs[4]  = mk(0, 0, 2'b00, 0, 0,  3, 0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 2'b00, 0, 0,  3, 1, 1, 0, 0);
    vecs[6]  = mk(1, 1, 2'b00, 0, 0,  3, 1, 1, 0, 0);
    vecs[7]  = mk(0, 1, 2'b00, 0, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 2'b11, 2, 0,  0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 2'b00, 0, 0,  0, 1, 2, 0, 0);
    vecs[10] = mk(1, 0, 2'b01, 3, 0,  0, 1, 2, 0, 0);
    vecs[11] = mk(1, 0, 2'b01, 1, 0,  2, 1, 2, 0, 0);
    vecs[12] = mk(0, 0, 2'b00, 0, 0,  1, 1, 2, 0, 0);
    vecs[13] = mk(0, 0, 2'b11, 2, 2,  1, 1, 2, 0, 0);
    vecs[14] = mk(0, 0, 2'b00, 0, 0,  1, 1, 3, 0, 1);
    vecs[15] = mk(0, 0, 2'b01, 0, 0,  1, 1, 3, 0, 1);
    vecs[16] = mk(0, 0, 2'b00, 0, 0,  0, 1, 4, 1, 1);

    rst = 1'b1;
    idle_a();
    b_yumi = 1'b0; b_prio = 1'b0; b_dv = 2'b00; b_did = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_a("reset_a", 2'd0, 1'b1, 3'd4, 1'b1, 1'b0);
    chk_b("reset_b", 3'd0, 1'b1, 3'd5, 1'b1, 1'b0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_yumi = vecs[i].yumi; a_prio = vecs[i].prio; a_dv = vecs[i].dv;
      a_id0 = vecs[i].id0; a_id1 = vecs[i].id1;
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].e_id, vecs[i].e_v, vecs[i].e_cnt, vecs[i].e_af, vecs[i].e_err);
    end

    // Double free of an ID that is already free after reset.
    do_reset();
    @(negedge clk);
    a_dv = 2'b01; a_id0 = 2'd3;
    #1 chk_a("dfree_pre", 2'd0, 1'b1, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    idle_a();
    #1 chk_a("dfree_post", 2'd0, 1'b1, 3'd4, 1'b1, 1'b1);

    // Alloc and dealloc of the ID currently on alloc_id_o in the same cycle.
    do_reset();
    @(negedge clk);
    a_yumi = 1'b1; a_dv = 2'b01; a_id0 = 2'd0;
    @(negedge clk);
    idle_a();
    #1 chk_a("alloc_dealloc_same", 2'd1, 1'b1, 3'd3, 1'b0, 1'b1);

    // Out-of-range ID on the 5-entry pool.
    @(negedge clk);
    b_dv = 2'b10; b_did = {3'd6, 3'd0};
    @(negedge clk);
    b_dv = 2'b00; b_did = '0;
    #1 chk_b("oor_b", 3'd0, 1'b1, 3'd5, 1'b1, 1'b1);

    // Asynchronous reset between edges with three IDs outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_yumi = 1'b1;
    end
    @(negedge clk);
    idle_a();
    #1 chk_a("three_out", 2'd3, 1'b0, 3'd1, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_a("async_reset", 2'd0, 1'b1, 3'd4, 1'b1, 1'b0);
    chk_b("async_reset_b", 3'd0, 1'b1, 3'd5, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
